// File: rtl/display_msg_sched_pkg.sv
// Shared display types: digit/message packing and the scheduler state encoding.
// Message builders elsewhere in the game use the same packing.
package display_pkg;

    typedef logic [6:0] digit_t;

    // Element [7] is d8 (leftmost digit), element [0] is d1.
    typedef digit_t [7:0] msg_t;

    // {enable, code[4:0], dp}: digit disabled, decimal point off.
    localparam digit_t BLANK_DIGIT = 7'b0000001;
    localparam msg_t   BLANK_MSG   = {8{BLANK_DIGIT}};

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        GAP
    } sched_state_t;

endpackage

// File: rtl/display_msg_sched_prio_pick.sv
// Combinational fixed-priority picker: the lowest-indexed active request wins.
module prio_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    output logic                    any,
    output logic [$clog2(NREQ)-1:0] idx
);

    localparam int IDW = $clog2(NREQ);

    // Scan from the top down so the lowest set index overwrites last.
    always_comb begin
        idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = i[IDW-1:0];
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/display_msg_sched.sv
// Time-shares the 8-digit display between prioritized message requesters,
// holding each granted message, then blanking for a gap before the next one.
module display_msg_sched
    import display_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int HOLD_CYCLES = 100_000_000,
    parameter int GAP_CYCLES  = 10_000_000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*56-1:0]      msg,
    input  logic [55:0]             default_msg,
    output logic [NREQ-1:0]         ack,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] active_id,
    output logic [6:0]              d1,
    output logic [6:0]              d2,
    output logic [6:0]              d3,
    output logic [6:0]              d4,
    output logic [6:0]              d5,
    output logic [6:0]              d6,
    output logic [6:0]              d7,
    output logic [6:0]              d8
);

    localparam int IDW     = $clog2(NREQ);
    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2((CNT_MAX > 2) ? CNT_MAX : 2);

    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    sched_state_t    r_state;
    sched_state_t    w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    msg_t            r_msg;
    msg_t            w_msg_nxt;
    logic [NREQ-1:0] r_ack;
    logic [NREQ-1:0] w_ack_nxt;
    logic            r_busy;
    logic            w_busy_nxt;
    logic [IDW-1:0]  r_active_id;
    logic [IDW-1:0]  w_active_id_nxt;

    logic            w_any;
    logic [IDW-1:0]  w_idx;
    logic            w_grant;
    logic            w_cnt_zero;
    logic            w_preempt;
    logic [55:0]     w_slot [NREQ];

    prio_pick #(
        .NREQ(NREQ)
    ) u_pick (
        .req(req),
        .any(w_any),
        .idx(w_idx)
    );

    for (genvar g = 0; g < NREQ; g++) begin : g_slot
        assign w_slot[g] = msg[56*g +: 56];
    end

    assign w_cnt_zero = (r_cnt == '0);

    // Only the urgent requester preempts, and never its own message.
    assign w_preempt = (r_state == SHOW) && req[0] && (r_active_id != '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_msg       <= BLANK_MSG;
            r_ack       <= '0;
            r_busy      <= 1'b0;
            r_active_id <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_msg       <= w_msg_nxt;
            r_ack       <= w_ack_nxt;
            r_busy      <= w_busy_nxt;
            r_active_id <= w_active_id_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_grant     = 1'b0;
        case (r_state)
            IDLE: begin
                w_grant = w_any;
            end
            SHOW: begin
                if (w_preempt) begin
                    w_grant = 1'b1;
                end else if (w_cnt_zero) begin
                    if (GAP_CYCLES > 0) begin
                        w_state_nxt = GAP;
                        w_cnt_nxt   = GAP_LOAD;
                    end else if (w_any) begin
                        w_grant = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            GAP: begin
                if (w_cnt_zero) begin
                    if (w_any) begin
                        w_grant = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        if (w_grant) begin
            w_state_nxt = SHOW;
            w_cnt_nxt   = HOLD_LOAD;
        end
    end

    // A grant latches the winner's slot; otherwise the display follows the next state.
    always_comb begin
        w_ack_nxt       = '0;
        w_busy_nxt      = (w_state_nxt != IDLE);
        w_active_id_nxt = r_active_id;
        w_msg_nxt       = r_msg;
        if (w_grant) begin
            w_ack_nxt[w_idx] = 1'b1;
            w_active_id_nxt  = w_idx;
            w_msg_nxt        = w_slot[w_idx];
        end else begin
            case (w_state_nxt)
                IDLE:    w_msg_nxt = default_msg;
                GAP:     w_msg_nxt = BLANK_MSG;
                default: w_msg_nxt = r_msg;
            endcase
        end
    end

    assign ack       = r_ack;
    assign busy      = r_busy;
    assign active_id = r_active_id;
    assign d1        = r_msg[0];
    assign d2        = r_msg[1];
    assign d3        = r_msg[2];
    assign d4        = r_msg[3];
    assign d5        = r_msg[4];
    assign d6        = r_msg[5];
    assign d7        = r_msg[6];
    assign d8        = r_msg[7];

endmodule

// File: tb/tb_display_msg_sched.sv
// Randomized scoreboard bench for display_msg_sched against a timeline-level
// model of the message schedule (hold/gap durations, priority, preemption).
module tb_display_msg_sched;

    localparam int NREQ   = 4;
    localparam int HOLD_N = 4;
    localparam int GAP_N  = 2;
    localparam logic [55:0] BLANK56 = {8{7'b0000001}};

    logic              clock = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [NREQ*56-1:0] msg;
    logic [55:0]       default_msg;
    logic [NREQ-1:0]   ack;
    logic              busy;
    logic [1:0]        active_id;
    logic [6:0]        d1, d2, d3, d4, d5, d6, d7, d8;
    logic [55:0]       dvec;

    display_msg_sched #(
        .NREQ(NREQ),
        .HOLD_CYCLES(HOLD_N),
        .GAP_CYCLES(GAP_N)
    ) dut (
        .clock(clock),
        .reset(reset),
        .req(req),
        .msg(msg),
        .default_msg(default_msg),
        .ack(ack),
        .busy(busy),
        .active_id(active_id),
        .d1(d1), .d2(d2), .d3(d3), .d4(d4),
        .d5(d5), .d6(d6), .d7(d7), .d8(d8)
    );

    always #5 clock = ~clock;

    assign dvec = {d8, d7, d6, d5, d4, d3, d2, d1};

    typedef struct packed {
        logic [55:0] d;
        logic        busy;
        logic [3:0]  ack;
        logic        aid_vld;
        logic [1:0]  aid;
    } frame_t;

    typedef struct packed {
        logic [1:0]  id;
        logic [55:0] m;
    } grant_t;

    frame_t exp_q[$];
    grant_t gnt_q[$];
    int     n_checks = 0;
    int     n_fail   = 0;
    int     ack_seen[NREQ];

    // Reference model: what is on the display and for how many more cycles.
    typedef enum int {M_IDLE, M_SHOW, M_BLANK} mmode_t;
    mmode_t      m_mode = M_IDLE;
    int          m_show_left = 0;
    int          m_gap_left = 0;
    int          m_cur = 0;
    logic [55:0] m_shown = '0;
    int          drop_id = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [NREQ-1:0] r);
        for (int i = 0; i < NREQ; i++) begin
            if (r[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [55:0] rand56();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[55:0];
    endfunction

    task automatic model_reset();
        m_mode      = M_IDLE;
        m_show_left = 0;
        m_gap_left  = 0;
        m_cur       = 0;
    endtask

    // Predict the outcome of the coming rising edge from the inputs now driven.
    task automatic model_step();
        int     g;
        frame_t f;
        grant_t gr;
        g = -1;
        case (m_mode)
            M_SHOW: begin
                if (req[0] && m_cur != 0) begin
                    g = 0;
                end else begin
                    m_show_left--;
                    if (m_show_left == 0) begin
                        if (GAP_N > 0) begin
                            m_mode     = M_BLANK;
                            m_gap_left = GAP_N;
                        end else if (req != 0) begin
                            g = lowest(req);
                        end else begin
                            m_mode = M_IDLE;
                        end
                    end
                end
            end
            M_BLANK: begin
                m_gap_left--;
                if (m_gap_left == 0) begin
                    if (req != 0) g = lowest(req);
                    else m_mode = M_IDLE;
                end
            end
            default: begin
                if (req != 0) g = lowest(req);
            end
        endcase
        f = '0;
        if (g >= 0) begin
            m_mode      = M_SHOW;
            m_show_left = HOLD_N;
            m_cur       = g;
            m_shown     = msg[56*g +: 56];
            drop_id     = g;
            f.ack[g]    = 1'b1;
            gr.id       = 2'(g);
            gr.m        = m_shown;
            gnt_q.push_back(gr);
        end
        case (m_mode)
            M_SHOW:  f.d = m_shown;
            M_BLANK: f.d = BLANK56;
            default: f.d = default_msg;
        endcase
        f.busy    = (m_mode != M_IDLE);
        f.aid_vld = (m_mode == M_SHOW);
        f.aid     = 2'(m_cur);
        exp_q.push_back(f);
    endtask

    task automatic next_cycle();
        @(negedge clock);
        if (drop_id >= 0) begin
            req[drop_id] = 1'b0;
            drop_id = -1;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            next_cycle();
            model_step();
        end
    endtask

    task automatic async_reset();
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("reset_d", dvec, BLANK56);
        check("reset_ack", ack, 4'b0000);
        check("reset_busy", busy, 1'b0);
        check("reset_active_id", active_id, 2'd0);
        exp_q.delete();
        gnt_q.delete();
        model_reset();
        @(posedge clock);
        #2;
        reset = 1'b0;
    endtask

    always @(posedge clock) begin
        frame_t f;
        grant_t g;
        #1;
        if (!reset && exp_q.size() > 0) begin
            f = exp_q.pop_front();
            check("display", dvec, f.d);
            check("busy", busy, f.busy);
            check("ack", ack, f.ack);
            if (f.aid_vld) check("active_id", active_id, f.aid);
            for (int i = 0; i < NREQ; i++) begin
                if (ack[i]) ack_seen[i]++;
            end
            if (ack != 0) begin
                if (gnt_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_ack: got %b expected no grant", ack);
                end else begin
                    g = gnt_q.pop_front();
                    check("grant_id", ack, 4'b0001 << g.id);
                    check("grant_msg", dvec, g.m);
                end
            end
        end
    end

    initial begin
        int before3;
        for (int i = 0; i < NREQ; i++) ack_seen[i] = 0;
        reset       = 1'b1;
        req         = '0;
        msg         = '0;
        default_msg = 56'hA5A5A5A5A5A5A5;
        #3;
        check("por_d", dvec, BLANK56);
        check("por_ack", ack, 4'b0000);
        check("por_busy", busy, 1'b0);
        check("por_active_id", active_id, 2'd0);
        @(posedge clock);
        #2;
        reset = 1'b0;
        idle_cycles(3);

        // Single request from slot 2.
        next_cycle();
        msg[2*56 +: 56] = 56'h0123456789ABCD;
        req[2] = 1'b1;
        model_step();
        idle_cycles(9);

        // Simultaneous requests 1 and 3: back-to-back with only a blank gap.
        next_cycle();
        msg[1*56 +: 56] = 56'h11223344556677;
        msg[3*56 +: 56] = 56'h33333333333333;
        req[1] = 1'b1;
        req[3] = 1'b1;
        model_step();
        idle_cycles(16);

        // Preemption of slot 2 by urgent requester 0.
        next_cycle();
        msg[2*56 +: 56] = 56'h22222222222222;
        req[2] = 1'b1;
        model_step();
        idle_cycles(2);
        next_cycle();
        msg[0] = 1'b0;
        msg[0*56 +: 56] = 56'h00FEDCBA987654;
        req[0] = 1'b1;
        model_step();
        idle_cycles(10);

        // Asynchronous reset on the third SHOW cycle; req[2] held through it.
        next_cycle();
        req[2] = 1'b1;
        model_step();
        idle_cycles(2);
        async_reset();
        req[2] = 1'b1;
        idle_cycles(10);

        // Withdrawn request: req[3] raised during SHOW and dropped before gap end.
        before3 = ack_seen[3];
        next_cycle();
        req[1] = 1'b1;
        model_step();
        idle_cycles(1);
        next_cycle();
        msg[3*56 +: 56] = 56'h3A3A3A3A3A3A3A;
        req[3] = 1'b1;
        model_step();
        idle_cycles(2);
        next_cycle();
        req[3] = 1'b0;
        model_step();
        idle_cycles(8);
        check("withdrawn_no_ack", ack_seen[3], before3);

        // Randomized traffic with occasional withdrawals and resets.
        for (int c = 0; c < 3000; c++) begin
            next_cycle();
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i]) begin
                    if ($urandom_range(0, 11) == 0) begin
                        msg[56*i +: 56] = rand56();
                        req[i] = 1'b1;
                    end
                end else if ($urandom_range(0, 39) == 0) begin
                    req[i] = 1'b0;
                end
            end
            if ($urandom_range(0, 15) == 0) default_msg = rand56();
            model_step();
            if ($urandom_range(0, 399) == 0) async_reset();
        end

        @(posedge clock);
        #3;
        check("grants_drained", gnt_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
